// File: rtl/sram_march_tester_pkg.sv
// Shared definitions for the SRAM march tester: FSM state encodings and default pattern seed.
package sram_march_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WRITE,
    ST_READ,
    ST_FINISH
  } tester_state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'h650F;

endpackage

// File: rtl/sram_req_handshake.sv
// Request/busy handshake toward the SPI SRAM encoder; pulses xfer_done on the busy 1->0 edge.
module sram_req_handshake (
  input  logic clk,
  input  logic reset_n,
  input  logic go,
  input  logic busy,
  output logic request,
  output logic xfer_done
);

  logic was_busy;

  // Completion is the first cycle busy is low again after having been seen high.
  assign xfer_done = request && was_busy && !busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      request  <= 1'b0;
      was_busy <= 1'b0;
    end else if (!request) begin
      was_busy <= 1'b0;
      if (go) request <= 1'b1;
    end else begin
      if (busy) was_busy <= 1'b1;
      if (xfer_done) request <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_march_tester.sv
// Write-then-read-back memory test sequencer driving the SPI SRAM encoder request side.
module sram_march_tester
  import sram_march_tester_pkg::*;
#(
  parameter int                       WORD_WIDTH    = 16,
  parameter int                       ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0] ADDR_FIRST    = '0,
  parameter logic [ADDRESS_WIDTH-1:0] ADDR_LAST     = '1,
  parameter logic [15:0]              SEED          = DEFAULT_SEED
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop_on_error,
  output logic                     request,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0]    data_out,
  input  logic                     busy,
  input  logic                     initialized,
  input  logic [WORD_WIDTH-1:0]    data_in,
  output logic                     running,
  output logic                     done,
  output logic                     pass,
  output logic [15:0]              error_count,
  output logic [ADDRESS_WIDTH-1:0] fail_address,
  output logic [WORD_WIDTH-1:0]    fail_expected,
  output logic [WORD_WIDTH-1:0]    fail_actual
);

  function automatic logic [WORD_WIDTH-1:0] pat(input logic [ADDRESS_WIDTH-1:0] a);
    return WORD_WIDTH'(a) ^ WORD_WIDTH'(SEED);
  endfunction

  tester_state_t           state;
  logic                    go, xfer_done;
  logic                    stop_q, miscmp, captured;
  logic [WORD_WIDTH-1:0]   expected;
  logic                    mismatch;

  assign expected = pat(address);
  assign mismatch = (data_in != expected);
  // Address/data settle while request is low; the handshake raises request the next cycle.
  assign go       = (state == ST_WRITE) || (state == ST_READ);

  sram_req_handshake u_hs (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (go),
    .busy      (busy),
    .request   (request),
    .xfer_done (xfer_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      address       <= ADDR_FIRST;
      write_enable  <= 1'b0;
      data_out      <= '0;
      running       <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      error_count   <= '0;
      fail_address  <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
      stop_q        <= 1'b0;
      miscmp        <= 1'b0;
      captured      <= 1'b0;
    end else begin
      miscmp <= 1'b0;
      if (miscmp && error_count != 16'hFFFF) error_count <= error_count + 16'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_WAIT_INIT;
            running       <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            error_count   <= '0;
            fail_address  <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            captured      <= 1'b0;
            stop_q        <= stop_on_error;
          end
        end
        ST_WAIT_INIT: begin
          if (initialized && !busy) begin
            state        <= ST_WRITE;
            address      <= ADDR_FIRST;
            write_enable <= 1'b1;
            data_out     <= pat(ADDR_FIRST);
          end
        end
        ST_WRITE: begin
          if (xfer_done) begin
            if (address == ADDR_LAST) begin
              state        <= ST_READ;
              address      <= ADDR_FIRST;
              write_enable <= 1'b0;
              data_out     <= '0;
            end else begin
              address  <= address + 1'b1;
              data_out <= pat(address + 1'b1);
            end
          end
        end
        ST_READ: begin
          if (xfer_done) begin
            if (mismatch) begin
              miscmp <= 1'b1;
              if (!captured) begin
                captured      <= 1'b1;
                fail_address  <= address;
                fail_expected <= expected;
                fail_actual   <= data_in;
              end
            end
            // Compare against the last address before incrementing, so an all-ones window never wraps.
            if ((mismatch && stop_q) || address == ADDR_LAST) state <= ST_FINISH;
            else address <= address + 1'b1;
          end
        end
        ST_FINISH: begin
          done    <= 1'b1;
          pass    <= !captured;
          running <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
